// File: rtl/bram_read_sequencer_if.sv
// Bus bundle for the BRAM read sequencer: command, BRAM read ports and word stream.
// The master modport is the sequencer; the slave modport is its surroundings.
interface bram_read_sequencer_if #(
  parameter int DATA_WIDTH = 1280,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [ADDR_WIDTH-1:0]           cmd_addr;
  logic [LEN_WIDTH-1:0]            cmd_len;
  logic                            clear;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] bram_addr;
  logic [NUM_PORTS-1:0]            bram_en;
  logic [NUM_PORTS*DATA_WIDTH-1:0] bram_rdata;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic                            busy;
  logic                            done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, clear, bram_rdata, out_ready,
    output cmd_ready, bram_addr, bram_en, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, clear, bram_rdata, out_ready,
    input  cmd_ready, bram_addr, bram_en, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/bram_read_sequencer.sv
// Multi-port BRAM read sequencer: fetches up to NUM_PORTS consecutive words per group,
// waits READ_LATENCY cycles, then streams them out one per valid/ready transfer.
module bram_read_sequencer #(
  parameter int DATA_WIDTH   = 1280,
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2,
  parameter int LEN_WIDTH    = 12
) (
  input  logic clk,
  input  logic rst,
  bram_read_sequencer_if.master bus
);
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int GCNT_W = $clog2(NUM_PORTS + 1);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam logic [LEN_WIDTH-1:0]  PORTS_LEN  = LEN_WIDTH'(NUM_PORTS);
  localparam logic [ADDR_WIDTH-1:0] PORTS_ADDR = ADDR_WIDTH'(NUM_PORTS);
  localparam logic [LAT_W-1:0]      LAT_LAST   = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t                          state, state_n;
  logic [ADDR_WIDTH-1:0]           base, base_n;
  logic [LEN_WIDTH-1:0]            words_left, left_n;
  logic [GCNT_W-1:0]               gcnt, gcnt_n;
  logic [IDX_W-1:0]                idx, idx_n;
  logic [LAT_W-1:0]                lat_cnt, lat_n;
  logic                            done_q, done_n;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [NUM_PORTS-1:0]            en_q, en_n;
  logic [IDX_W-1:0]                last_idx;
  logic                            xfer;
  logic [DATA_WIDTH-1:0]           data_sel;

  function automatic logic [GCNT_W-1:0] group_size(input logic [LEN_WIDTH-1:0] left);
    if (left >= PORTS_LEN) return GCNT_W'(NUM_PORTS);
    return GCNT_W'(left);
  endfunction

  assign last_idx = IDX_W'(gcnt - 1'b1);
  assign xfer     = (state == DRAIN) && bus.out_ready;

  // State and datapath registers; everything returns to its idle value on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      words_left <= '0;
      gcnt       <= '0;
      idx        <= '0;
      lat_cnt    <= '0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      en_q       <= '0;
    end else begin
      state      <= state_n;
      base       <= base_n;
      words_left <= left_n;
      gcnt       <= gcnt_n;
      idx        <= idx_n;
      lat_cnt    <= lat_n;
      done_q     <= done_n;
      addr_q     <= addr_n;
      en_q       <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    base_n  = base;
    left_n  = words_left;
    gcnt_n  = gcnt;
    idx_n   = idx;
    lat_n   = lat_cnt;
    done_n  = 1'b0;
    addr_n  = '0;
    en_n    = '0;
    if (bus.clear) begin
      state_n = IDLE;
      left_n  = '0;
      idx_n   = '0;
      lat_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && (bus.cmd_len != '0)) begin
            state_n = WAIT;
            base_n  = bus.cmd_addr;
            left_n  = bus.cmd_len;
            gcnt_n  = group_size(bus.cmd_len);
            lat_n   = '0;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state_n = DRAIN;
            idx_n   = '0;
          end else begin
            lat_n = lat_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (idx == last_idx) begin
              left_n = words_left - LEN_WIDTH'(gcnt);
              idx_n  = '0;
              if (left_n == '0) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end else begin
                state_n = WAIT;
                base_n  = base + PORTS_ADDR;
                gcnt_n  = group_size(left_n);
                lat_n   = '0;
              end
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Addresses follow the next base so they are already stable on entry to WAIT.
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_n[p*ADDR_WIDTH +: ADDR_WIDTH] = base_n + ADDR_WIDTH'(p);
      en_n[p] = (state_n != IDLE) && (GCNT_W'(p) < gcnt_n);
    end
  end

  always_comb begin
    data_sel = bus.bram_rdata[DATA_WIDTH-1:0];
    for (int p = 1; p < NUM_PORTS; p++) begin
      if (idx == IDX_W'(p)) data_sel = bus.bram_rdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.out_data  = data_sel;
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_last  = (state == DRAIN) && (idx == last_idx) && (words_left == LEN_WIDTH'(gcnt));
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_en   = en_q;
endmodule

// File: tb/tb_bram_read_sequencer.sv
// Bench for bram_read_sequencer: BRAM bank model, queue-based reference of the word
// stream and its timing, directed corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_bram_read_sequencer;
  localparam int DW = 1280;
  localparam int NP = 2;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int LW = 12;
  localparam int unsigned ASPACE = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    bit            gend;
    int unsigned   gaddr;
    int            gcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          ready_at = 0;
  bit          done_pend = 1'b0;
  int unsigned seed;
  exp_t        expq[$];
  exp_t        head;
  bit          exp_valid;
  logic [NP-1:0] exp_en;
  logic [NP*DW-1:0] pipe [RL];

  bram_read_sequencer_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus();

  bram_read_sequencer #(
    .DATA_WIDTH(DW), .NUM_PORTS(NP), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Content of bank `port` at `addr`; the port index is mixed in so a wrong bank is visible.
  function automatic logic [DW-1:0] word_of(input int unsigned addr, input int unsigned port);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++)
      w[k*32 +: 32] = (addr * 32'h9E3779B1) ^ (port * 32'h7F4A7C15) ^ (32'(k) * 32'h01000193) ^ seed;
    return w;
  endfunction

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (bus.bram_en[p]) pipe[0][p*DW +: DW] <= word_of(32'(bus.bram_addr[p*AW +: AW]), 32'(p));
    for (int s = 1; s < RL; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.bram_rdata = pipe[RL-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic checkData(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got low64 %h, expected low64 %h (cycle %0d)", name, act[63:0], exp[63:0], cycle);
    end
  endtask

  // Expected stream of an accepted command: word i comes from address base+i on bank i%NP.
  task automatic modelAccept(input int unsigned addr, input int unsigned len);
    for (int i = 0; i < int'(len); i++) begin
      exp_t e;
      int g0;
      g0      = i - (i % NP);
      e.data  = word_of((addr + 32'(i)) % ASPACE, 32'(i % NP));
      e.last  = (i == int'(len) - 1);
      e.gend  = ((i % NP) == NP - 1) || e.last;
      e.gaddr = (addr + 32'(g0)) % ASPACE;
      e.gcnt  = (int'(len) - g0 < NP) ? int'(len) - g0 : NP;
      expq.push_back(e);
    end
  endtask

  // One compare per cycle against the reference queue, then the reference advances.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      expq.delete();
      done_pend = 1'b0;
    end else begin
      exp_valid = (expq.size() > 0) && (cycle >= ready_at);
      checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      checkOutput("busy", 64'(bus.busy), 64'(expq.size() > 0));
      checkOutput("cmd_ready", 64'(bus.cmd_ready), 64'(expq.size() == 0));
      checkOutput("done", 64'(bus.done), 64'(done_pend));
      done_pend = 1'b0;
      exp_en = '0;
      if (expq.size() > 0) begin
        head = expq[0];
        for (int p = 0; p < head.gcnt; p++) begin
          exp_en[p] = 1'b1;
          checkOutput("bram_addr", 64'(bus.bram_addr[p*AW +: AW]), 64'((head.gaddr + 32'(p)) % ASPACE));
        end
      end
      checkOutput("bram_en", 64'(bus.bram_en), 64'(exp_en));
      if (exp_valid && bus.out_valid) begin
        checkData("out_data", bus.out_data, head.data);
        checkOutput("out_last", 64'(bus.out_last), 64'(head.last));
      end
      if (bus.clear) begin
        expq.delete();
      end else if (expq.size() == 0) begin
        if (bus.cmd_valid && (bus.cmd_len != '0)) begin
          modelAccept(32'(bus.cmd_addr), 32'(bus.cmd_len));
          ready_at = cycle + RL + 1;
        end
      end else if (exp_valid && bus.out_ready) begin
        void'(expq.pop_front());
        if (head.last) done_pend = 1'b1;
        else if (head.gend) ready_at = cycle + RL + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int unsigned addr, input int unsigned len);
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = LW'(len);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("idle_timeout", 64'(bus.cmd_ready), 64'(1));
    tick();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    seed          = $urandom;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_bram_en", 64'(bus.bram_en), 64'(0));
    checkOutput("rst_bram_addr", 64'(bus.bram_addr), 64'(0));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    tick();
    tick();
    rst = 1'b0;

    // Single word: enable/address one cycle after acceptance, word after the latency.
    applyStimulus(5, 1);
    checkOutput("single_en", 64'(bus.bram_en), 64'(2'b01));
    checkOutput("single_addr0", 64'(bus.bram_addr[AW-1:0]), 64'(5));
    tick(); tick();
    checkOutput("single_valid", 64'(bus.out_valid), 64'(1));
    checkOutput("single_last", 64'(bus.out_last), 64'(1));
    checkData("single_data", bus.out_data, word_of(5, 0));
    tick();
    checkOutput("single_done", 64'(bus.done), 64'(1));
    tick();

    // Five words in three groups with a latency bubble between groups.
    applyStimulus(0, 5);
    checkOutput("multi_en_g0", 64'(bus.bram_en), 64'(2'b11));
    checkOutput("multi_addr_g0", 64'(bus.bram_addr), 64'({12'd1, 12'd0}));
    tick(); tick();
    checkOutput("multi_valid_w0", 64'(bus.out_valid), 64'(1));
    checkOutput("multi_last_w0", 64'(bus.out_last), 64'(0));
    checkData("multi_data_w0", bus.out_data, word_of(0, 0));
    tick(); tick();
    checkOutput("multi_bubble", 64'(bus.out_valid), 64'(0));
    checkOutput("multi_addr_g1", 64'(bus.bram_addr), 64'({12'd3, 12'd2}));
    tick(); tick(); tick(); tick();
    checkOutput("multi_en_g2", 64'(bus.bram_en), 64'(2'b01));
    checkOutput("multi_addr0_g2", 64'(bus.bram_addr[AW-1:0]), 64'(4));
    tick(); tick();
    checkOutput("multi_last_w4", 64'(bus.out_last), 64'(1));
    checkData("multi_data_w4", bus.out_data, word_of(4, 0));
    tick();
    checkOutput("multi_done", 64'(bus.done), 64'(1));
    tick();

    // Backpressure in the middle of the first group.
    applyStimulus(100, 4);
    tick(); tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkData("bp_data_hold", bus.out_data, word_of(101, 1));
      checkOutput("bp_addr_hold", 64'(bus.bram_addr[AW-1:0]), 64'(100));
      tick();
    end
    wait_idle();

    // Asynchronous reset while draining.
    applyStimulus(200, 4);
    bus.out_ready = 1'b0;
    tick(); tick();
    checkOutput("mid_valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("arst_bram_en", 64'(bus.bram_en), 64'(0));
    checkOutput("arst_busy", 64'(bus.busy), 64'(0));
    checkOutput("arst_done", 64'(bus.done), 64'(0));
    checkOutput("arst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Address wrap at the top of the space.
    applyStimulus(4094, 3);
    checkOutput("wrap_addr_g0", 64'(bus.bram_addr), 64'({12'd4095, 12'd4094}));
    tick(); tick(); tick(); tick();
    checkOutput("wrap_en_g1", 64'(bus.bram_en), 64'(2'b01));
    checkOutput("wrap_addr0_g1", 64'(bus.bram_addr[AW-1:0]), 64'(0));
    wait_idle();

    // Zero-length command is a no-op.
    applyStimulus(7, 0);
    checkOutput("len0_busy", 64'(bus.busy), 64'(0));
    tick();
    checkOutput("len0_done", 64'(bus.done), 64'(0));

    // Clear while draining, then a fresh command runs normally.
    applyStimulus(300, 6);
    tick(); tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checkOutput("clr_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("clr_en", 64'(bus.bram_en), 64'(0));
    checkOutput("clr_busy", 64'(bus.busy), 64'(0));
    tick();
    checkOutput("clr_no_done", 64'(bus.done), 64'(0));
    applyStimulus(40, 3);
    wait_idle();

    // Commands offered while busy are ignored.
    applyStimulus(500, 3);
    bus.cmd_addr  = AW'(9);
    bus.cmd_len   = LW'(5);
    bus.cmd_valid = 1'b1;
    tick(); tick(); tick();
    bus.cmd_valid = 1'b0;
    wait_idle();

    // Randomized traffic: commands, backpressure and occasional clears.
    for (int c = 0; c < 4000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.clear     = ($urandom_range(0, 99) == 0);
      bus.cmd_valid = ($urandom_range(0, 3) == 0);
      bus.cmd_addr  = ($urandom_range(0, 7) == 0) ? AW'(ASPACE - $urandom_range(1, 4)) : AW'($urandom);
      bus.cmd_len   = ($urandom_range(0, 9) == 0) ? LW'(0) : LW'($urandom_range(1, 9));
      tick();
    end
    bus.clear     = 1'b0;
    bus.cmd_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bram_read_sequencer.md
Name: bram_read_sequencer

Overview:
Multi-port BRAM read sequencer for MAC weight fetch. It accepts a command of a base address and a word count. It reads up to NUM_PORTS consecutive BRAM words per group, one word per port, waiting a parameterised read latency for each group. It then streams the words out one per transfer with a valid/ready handshake and a last flag. It sits between the weight BRAM banks and the MAC array input, generalising the fixed two-port, fixed-latency weight reader to N ports, a programmable latency, arbitrary lengths and backpressure.

Parameters:
DATA_WIDTH, 1280, bits per BRAM word (5*MAC_NUM, MAC_NUM=256)
NUM_PORTS, 2, number of BRAM read ports/banks read in parallel (>=1)
ADDR_WIDTH, 12, BRAM address width
READ_LATENCY, 2, cycles from address register to valid rdata (>=1)
LEN_WIDTH, 12, width of the command word count

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_WIDTH  base word address
cmd_len  in  LEN_WIDTH  words to read; 0 = no-op
clear  in  1  synchronous abort to IDLE
bram_addr  out  NUM_PORTS*ADDR_WIDTH  port p slice = address for port p
bram_en  out  NUM_PORTS  per-port read enable
bram_rdata  in  NUM_PORTS*DATA_WIDTH  port p slice = read data
out_data  out  DATA_WIDTH  current word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_last  out  1  final word of command, qualified by out_valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset (rst=1, async): state IDLE; base, words_left, idx, latency counter = 0. Outputs: bram_en=0, bram_addr=0, out_valid=0, out_last=0, busy=0, done=0, cmd_ready=1.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - cmd_valid=1 and cmd_len!=0: latch base=cmd_addr and words_left=cmd_len; go to WAIT with lat_cnt=0.
  - cmd_len=0: accepted, no effect, stay IDLE, no done.
- Group size: gcnt = min(NUM_PORTS, words_left), evaluated at group start and held until the group ends.
- Addressing: port p address = (base+p) mod 2^ADDR_WIDTH, so the address wraps at the top of the space. bram_en[p]=1 in WAIT and DRAIN for p<gcnt, else 0. Addresses and enables are registered and held stable through WAIT and DRAIN.
- WAIT: lasts exactly READ_LATENCY cycles, then DRAIN with idx=0. With a command accepted at edge t, the first out_valid=1 is in cycle t+READ_LATENCY+1.
- DRAIN:
  - out_valid=1; out_data = bram_rdata slice idx.
  - out_last=1 when idx==gcnt-1 and words_left==gcnt.
  - On each transfer (out_valid & out_ready): idx+1.
  - Transfer with idx==gcnt-1: words_left -= gcnt.
    - words_left reaches 0: go to IDLE and assert done the next cycle.
    - otherwise: base += NUM_PORTS (mod 2^ADDR_WIDTH), recompute gcnt, go to WAIT.
  - out_ready=0: hold idx, data and addresses. BRAM output stays stable because the address is unchanged.
- cmd_valid outside IDLE is ignored.
- clear=1: next state IDLE. Drops the group and remaining words; out_valid, bram_en and busy go to 0 next cycle; no done. clear has priority over a simultaneous command or transfer.
- Reset mid-operation: immediate return to reset values; no partial transfer is reported.
- Throughput: at most one word per cycle in DRAIN. There is no address prefetch; each group costs READ_LATENCY bubble cycles.

Test Plan:
1. Reset: rst pulse during DRAIN -> out_valid, bram_en, busy, done drop to 0 immediately and cmd_ready=1, with no clock edge required.
2. Single word, NUM_PORTS=2, READ_LATENCY=2:
   - Stimulus: cmd addr=5, len=1 accepted at edge t.
   - Required: bram_en=01 and port0 addr=5 from t+1; out_valid=1, out_last=1 at t+3 with port0 data; done at t+4.
3. Multi-group, len=5, addr=0, out_ready=1:
   - Addresses (0,1), then (2,3), then (4,-) with bram_en=01.
   - Five words out in order; 2-cycle bubble between groups; out_last only on word 4.
4. Backpressure: len=4, out_ready=0 for 3 cycles mid-group -> out_data and bram_addr held, idx unchanged, no word lost or duplicated.
5. Wrap-around: addr=4094, len=3 -> addresses 4094, 4095, then 0; data emitted in that order.
6. Control corner cases:
   - cmd_len=0 -> nothing happens, no done.
   - clear while in DRAIN -> IDLE next cycle with no done; a new command is then accepted and runs normally.
   - cmd_valid while busy -> ignored.
